// File: rtl/buzzer_event_decoder.sv
// Buzzer pulse-width decoder: classifies one-hot buzzer pulses,
// queues events for a host and keeps per-zone good-alarm counts.
module buzzer_event_decoder #(
   parameter int unsigned PULSE_LEN  = 31,
   parameter int unsigned TOL        = 2,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic [2:0]       buzz_in,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [3:0]       evt_data,
   output logic [CNT_W-1:0] cnt_z1,
   output logic [CNT_W-1:0] cnt_z2,
   output logic [CNT_W-1:0] cnt_z3,
   output logic             drop,
   output logic             busy
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [6:0] LO = 7'(PULSE_LEN - TOL);
   localparam logic [6:0] HI = 7'(PULSE_LEN + TOL);
   localparam logic [CNT_W-1:0] CMAX = '1;

   typedef enum logic [1:0] {
      IDLE,
      MEASURE,
      WAIT_CLEAR
   } state_e;

   state_e        state_q, state_d;
   logic [2:0]    buzz_q, buzz_d;
   logic [2:0]    line_q, line_d;
   logic [5:0]    width_q, width_d;
   logic [5:0]    width_inc;
   logic          one_hot;
   logic          push;
   logic [3:0]    push_data;
   logic [1:0]    kind;

   logic [3:0]    mem_q [FIFO_DEPTH];
   logic [AW:0]   wptr_q, rptr_q;
   logic          full, empty, pop, wr;
   logic          drop_q;
   logic [CNT_W-1:0] cnt1_q, cnt2_q, cnt3_q;

   function automatic logic [1:0] zone_of(input logic [2:0] l);
      logic [1:0] z;
      z = 2'd0;
      unique case (1'b1)
         l[0]:    z = 2'd1;
         l[1]:    z = 2'd2;
         l[2]:    z = 2'd3;
         default: z = 2'd0;
      endcase
      return z;
   endfunction

   assign one_hot   = (buzz_q != 3'd0) &&
                      ((buzz_q & (buzz_q - 3'd1)) == 3'd0);
   assign width_inc = (width_q == 6'd63) ? 6'd63 : width_q + 6'd1;
   assign buzz_d    = ena ? buzz_in : buzz_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         buzz_q  <= '0;
         line_q  <= '0;
         width_q <= '0;
      end else begin
         state_q <= state_d;
         buzz_q  <= buzz_d;
         line_q  <= line_d;
         width_q <= width_d;
      end
   end

   always_comb begin
      state_d = state_q;
      line_d  = line_q;
      width_d = width_q;
      if (ena) begin
         unique case (state_q)
            IDLE: begin
               if (one_hot) begin
                  line_d  = buzz_q;
                  width_d = 6'd1;
                  state_d = MEASURE;
               end else if (buzz_q != 3'd0) begin
                  state_d = WAIT_CLEAR;
               end
            end
            MEASURE: begin
               if (buzz_q == line_q) begin
                  width_d = width_inc;
                  if ({1'b0, width_inc} > HI) state_d = WAIT_CLEAR;
               end else if (buzz_q == 3'd0) begin
                  state_d = IDLE;
               end else begin
                  state_d = WAIT_CLEAR;
               end
            end
            WAIT_CLEAR: begin
               if (buzz_q == 3'd0) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Classification of a completed pulse on the falling sample
   always_comb begin
      kind = 2'b00;
      if ({1'b0, width_q} < LO)      kind = 2'b01;
      else if ({1'b0, width_q} > HI) kind = 2'b10;
   end

   always_comb begin
      push      = 1'b0;
      push_data = 4'd0;
      if (ena) begin
         unique case (state_q)
            IDLE: begin
               if (!one_hot && buzz_q != 3'd0) begin
                  push      = 1'b1;
                  push_data = 4'b1100;
               end
            end
            MEASURE: begin
               if (buzz_q == line_q) begin
                  if ({1'b0, width_inc} > HI) begin
                     push      = 1'b1;
                     push_data = {2'b10, zone_of(line_q)};
                  end
               end else if (buzz_q == 3'd0) begin
                  push      = 1'b1;
                  push_data = {kind, zone_of(line_q)};
               end else begin
                  push      = 1'b1;
                  push_data = 4'b1100;
               end
            end
            default: ;
         endcase
      end
   end

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) &&
                  (wptr_q[AW] != rptr_q[AW]);
   assign pop   = !empty && evt_ready;
   assign wr    = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         drop_q <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (wr) begin
            mem_q[wptr_q[AW-1:0]] <= push_data;
            wptr_q <= wptr_q + 1'b1;
         end
         if (pop) rptr_q <= rptr_q + 1'b1;
         if (push && !wr) drop_q <= 1'b1;
      end
   end

   // Good events count even when the FIFO had no room for them
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt1_q <= '0;
         cnt2_q <= '0;
         cnt3_q <= '0;
      end else if (push && push_data[3:2] == 2'b00) begin
         if (push_data[1:0] == 2'd1 && cnt1_q != CMAX) cnt1_q <= cnt1_q + 1'b1;
         if (push_data[1:0] == 2'd2 && cnt2_q != CMAX) cnt2_q <= cnt2_q + 1'b1;
         if (push_data[1:0] == 2'd3 && cnt3_q != CMAX) cnt3_q <= cnt3_q + 1'b1;
      end
   end

   assign evt_valid = !empty;
   assign evt_data  = mem_q[rptr_q[AW-1:0]];
   assign cnt_z1    = cnt1_q;
   assign cnt_z2    = cnt2_q;
   assign cnt_z3    = cnt3_q;
   assign drop      = drop_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_buzzer_event_decoder.sv
// Bench for buzzer_event_decoder: directed scenarios plus random
// pulse trains, checked against a pulse-level reference model.
module tb_buzzer_event_decoder;

   logic       clk = 1'b0;
   logic       rst, ena, evt_ready;
   logic [2:0] buzz_in;
   logic       evt_valid, drop, busy;
   logic [3:0] evt_data;
   logic [7:0] cnt_z1, cnt_z2, cnt_z3;

   int n_cmp = 0;
   int n_err = 0;

   logic [3:0] m_q[$];
   logic [2:0] m_bq;
   logic [2:0] m_line;
   int         m_run;
   bit         m_blk;
   int         m_cnt[3];
   bit         m_drop;

   logic [3:0] last_pop;
   int         n_pops;

   always #5 clk = ~clk;

   buzzer_event_decoder #(
      .PULSE_LEN(31), .TOL(2), .FIFO_DEPTH(4), .CNT_W(8)
   ) dut (
      .clk(clk), .rst(rst), .ena(ena), .buzz_in(buzz_in),
      .evt_valid(evt_valid), .evt_ready(evt_ready),
      .evt_data(evt_data), .cnt_z1(cnt_z1), .cnt_z2(cnt_z2),
      .cnt_z3(cnt_z3), .drop(drop), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] zcode(input logic [2:0] l);
      if (l == 3'b001) return 2'd1;
      if (l == 3'b010) return 2'd2;
      return 2'd3;
   endfunction

   // Reference: a pulse is a run of identical one-hot samples; anything
   // malformed blocks further decoding until the lines go quiet.
   task automatic model_edge();
      logic [3:0] ev;
      bit has, pop, full;
      if (rst) begin
         m_q.delete();
         m_bq = 0; m_line = 0; m_run = 0; m_blk = 0; m_drop = 0;
         foreach (m_cnt[i]) m_cnt[i] = 0;
         return;
      end
      has = 0;
      ev  = 0;
      pop  = (m_q.size() != 0) && evt_ready;
      full = (m_q.size() == 4);
      if (ena) begin
         if (m_blk) begin
            if (m_bq == 0) m_blk = 0;
         end else if (m_line == 0) begin
            if ($countones(m_bq) == 1) begin
               m_line = m_bq; m_run = 1;
            end else if (m_bq != 0) begin
               has = 1; ev = 4'b1100; m_blk = 1;
            end
         end else if (m_bq == m_line) begin
            m_run++;
            if (m_run > 33) begin
               has = 1; ev = {2'b10, zcode(m_line)};
               m_blk = 1; m_line = 0;
            end
         end else if (m_bq == 0) begin
            has = 1;
            if (m_run < 29)      ev = {2'b01, zcode(m_line)};
            else if (m_run > 33) ev = {2'b10, zcode(m_line)};
            else                 ev = {2'b00, zcode(m_line)};
            m_line = 0;
         end else begin
            has = 1; ev = 4'b1100; m_blk = 1; m_line = 0;
         end
         m_bq = buzz_in;
      end
      if (pop) void'(m_q.pop_front());
      if (has) begin
         if (ev[3:2] == 2'b00 && m_cnt[ev[1:0]-1] < 255)
            m_cnt[ev[1:0]-1]++;
         if (full && !pop) m_drop = 1;
         else m_q.push_back(ev);
      end
   endtask

   task automatic step();
      if (evt_valid && evt_ready) begin
         last_pop = evt_data;
         n_pops++;
      end
      @(posedge clk);
      model_edge();
      #1;
      chk("valid", evt_valid, m_q.size() != 0);
      if (m_q.size() != 0) chk("data", evt_data, m_q[0]);
      chk("busy", busy, m_blk || (m_line != 0));
      chk("drop", drop, m_drop);
      chk("cnt1", cnt_z1, m_cnt[0]);
      chk("cnt2", cnt_z2, m_cnt[1]);
      chk("cnt3", cnt_z3, m_cnt[2]);
   endtask

   task automatic pulse(input logic [2:0] l, input int len, input int gap);
      buzz_in = l;
      repeat (len) step();
      buzz_in = 3'b000;
      repeat (gap) step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      int p0;
      rst = 1'b1; ena = 1'b1; evt_ready = 1'b1; buzz_in = 3'b000;
      last_pop = 4'hf; n_pops = 0;
      step();
      chk("rst_valid", evt_valid, 1'b0);
      chk("rst_data", evt_data, 4'd0);
      chk("rst_busy", busy, 1'b0);
      rst = 1'b0;
      step();

      pulse(3'b010, 31, 4);
      chk("good_z2", last_pop, 4'b0010);
      chk("good_z2_cnt", cnt_z2, 8'd1);

      pulse(3'b001, 10, 4);
      chk("short_z1", last_pop, 4'b0101);

      p0 = n_pops;
      buzz_in = 3'b100;
      repeat (37) step();
      chk("long_busy", busy, 1'b1);
      chk("long_early", last_pop, 4'b1011);
      buzz_in = 3'b000;
      repeat (4) step();
      chk("long_once", n_pops - p0, 1);
      chk("long_idle", busy, 1'b0);

      pulse(3'b011, 3, 4);
      chk("multi", last_pop, 4'b1100);
      p0 = n_pops;
      buzz_in = 3'b001;
      repeat (5) step();
      pulse(3'b010, 5, 4);
      chk("z1z2_multi", last_pop, 4'b1100);
      chk("z1z2_once", n_pops - p0, 1);

      do_reset();
      evt_ready = 1'b0;
      repeat (5) pulse(3'b001, 31, 2);
      chk("full_drop", drop, 1'b1);
      chk("full_cnt", cnt_z1, 8'd5);
      p0 = n_pops;
      evt_ready = 1'b1;
      repeat (6) step();
      chk("drain", n_pops - p0, 4);

      do_reset();
      evt_ready = 1'b0;
      repeat (4) pulse(3'b010, 31, 2);
      buzz_in = 3'b010;
      repeat (31) step();
      buzz_in = 3'b000;
      step();
      evt_ready = 1'b1;
      step();
      evt_ready = 1'b0;
      step();
      chk("pushpop_full", drop, 1'b0);
      chk("pushpop_valid", evt_valid, 1'b1);

      evt_ready = 1'b1;
      repeat (6) step();
      buzz_in = 3'b001;
      repeat (16) step();
      rst = 1'b1;
      step();
      chk("mid_rst_valid", evt_valid, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_cnt", cnt_z2, 8'd0);
      rst = 1'b0;
      pulse(3'b001, 15, 4);
      chk("mid_rst_short", last_pop, 4'b0101);

      do_reset();
      repeat (257) pulse(3'b001, 31, 1);
      repeat (3) step();
      chk("sat_cnt", cnt_z1, 8'd255);

      do_reset();
      repeat (200) begin
         logic [2:0] l;
         int len, gap;
         if ($urandom_range(0, 9) < 7) l = 3'b001 << $urandom_range(0, 2);
         else begin
            l = 3'($urandom_range(3, 7));
            if (l == 3'b100) l = 3'b111;
         end
         len = $urandom_range(1, 45);
         gap = $urandom_range(0, 3);
         buzz_in = l;
         repeat (len + gap) begin
            ena       = ($urandom_range(0, 9) != 0);
            evt_ready = 1'($urandom_range(0, 1));
            rst       = ($urandom_range(0, 299) == 0);
            step();
            if (len > 0) begin
               len--;
               if (len == 0) buzz_in = 3'b000;
            end
         end
      end
      rst = 1'b0; ena = 1'b1; evt_ready = 1'b1; buzz_in = 3'b000;
      repeat (10) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/buzzer_event_decoder.md
# buzzer_event_decoder

Receive-side decoder for the three buzzer lines driven by the sensor alarm block. It watches the one-hot buzzer pulses, checks each pulse's width against the nominal 31-cycle alarm length, and classifies it. Each classified event is pushed into a small FIFO that a host reads with a valid/ready handshake. It also keeps saturating per-zone counts of good alarms, and it sits on the same clock as the alarm block, downstream of its outputs.

## Interface

**Parameters**
- PULSE_LEN, 31 — nominal buzzer high time in cycles.
- TOL, 2 — accepted deviation in cycles; good when PULSE_LEN-TOL ≤ width ≤ PULSE_LEN+TOL.
- FIFO_DEPTH, 4 — event FIFO entries; must be a power of two, ≥2.
- CNT_W, 8 — width of each per-zone counter.

**Ports**
- clk  in  1  — single clock; all logic on rising edge.
- rst  in  1  — synchronous, active-high reset.
- ena  in  1  — decode enable.
- buzz_in  in  3  — buzzer lines; bit0 = zone 1, bit1 = zone 2, bit2 = zone 3.
- evt_valid  out  1  — FIFO head holds an event.
- evt_ready  in  1  — host accepts the head event.
- evt_data  out  4  — fields:
  - [1:0] zone: 1/2/3, or 0 for a multi-hot event.
  - [3:2] kind: 00 good, 01 short, 10 long, 11 multi-hot.
- cnt_z1, cnt_z2, cnt_z3  out  CNT_W  — good-event counts per zone.
- drop  out  1  — sticky flag: an event was lost to a full FIFO.
- busy  out  1  — FSM not in IDLE.

## Operation

**Input stage and enable**
- buzz_in is registered once into buzz_q. All FSM decisions use buzz_q.
- When ena=0:
  - buzz_q, the FSM, width and the counters hold.
  - The FIFO pop side keeps working.

**FSM states**
- IDLE:
  - buzz_q==0: stay.
  - buzz_q one-hot: latch zone, set width=1, go to MEASURE.
  - buzz_q multi-hot: push {11,00}, go to WAIT_CLEAR.
- MEASURE:
  - buzz_q == latched line: width+1.
    - If the new width would exceed PULSE_LEN+TOL, push {10,zone} and go to WAIT_CLEAR.
  - buzz_q==0: classify width as short (<PULSE_LEN-TOL), long, or good. Push {kind,zone} and go to IDLE.
  - Any other nonzero buzz_q: push {11,00}, go to WAIT_CLEAR.
- WAIT_CLEAR:
  - Stay until buzz_q==0, then go to IDLE. No push on the exit.

**Width counter**
- 6 bits, saturating at 63.
- The width compare is unsigned. PULSE_LEN-TOL is computed as a 7-bit value with no underflow (TOL < PULSE_LEN).

**Counters**
- A good push increments the matching cnt_zN.
- Each cnt_zN saturates at all-ones and never wraps.
- A counter increments even if the push was dropped.

**FIFO**
- Circular buffer with pointer width log2(FIFO_DEPTH)+1.
- Push while full and not popping: the event is discarded and drop is set. drop stays 1 until rst.
- Push and pop in the same cycle while full: both take effect; nothing is dropped.
- Push and pop in the same cycle while empty: the push lands. No bypass: evt_valid rises the following cycle.

**Handshake**
- A pop occurs on any edge with evt_valid && evt_ready.
- evt_data is stable while evt_valid=1 and no pop occurs.
- The host may hold evt_ready high continuously.

## Timing

**Reset values**
- Reset clears every register in one edge: evt_valid=0, evt_data=0, cnt_z*=0, drop=0, busy=0, buzz_q=0, FSM=IDLE, FIFO empty.
- A reset mid-pulse discards the measurement. If the line is still high after reset, measurement starts fresh with width from 1 (a short event follows).

**Latency**
- buzz_in edge sampled at edge N reaches buzz_q at N.
- The FSM acts (push, state change) at N+1.
- evt_valid=1 and the cnt_zN update are visible after N+1.
- A pulse of exactly PULSE_LEN cycles has width=PULSE_LEN at classification.

**Back-to-back pulses**
- A one-hot buzz_q arriving in the cycle after IDLE is entered starts a new MEASURE with no gap required.

**Ready behaviour**
- evt_ready ignored while evt_valid=0.

## Test plan

- Zone 2 high for 31 cycles with ena=1, evt_ready=1 → evt_data=4'b0010 valid for one cycle, 2 cycles after the falling sample; cnt_z2=1.
- Zone 1 high for 10 cycles → evt_data=4'b0101.
- Zone 3 high for 40 cycles → evt_data=4'b1011, pushed when width reaches 34 (before the line falls); no second event when the line clears; busy stays 1 until then.
- buzz_in=3'b011 → evt_data=4'b1100. Separately, zone 1 for 5 cycles followed directly by zone 2 → one multi-hot event, then WAIT_CLEAR.
- evt_ready=0 with 5 good zone-1 pulses, then drain → 4 events read, drop=1, cnt_z1=5. Also push and pop in the same cycle while full → no drop.
- rst asserted mid-pulse at width 15 → all outputs 0 the next cycle. The remaining 16 high cycles yield a short event {01,zone}. A 2^CNT_W+1 good-pulse run saturates cnt_z1 at 255.
